// File: rtl/stopwatch_counter_if.sv
// Signal bundle between the stopwatch core and whatever drives its controls
// and reads its BCD display digits.
interface stopwatch_counter_if;
    logic       tick_1hz;
    logic       key_start_n;
    logic       clr;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       rollover;

    modport master (
        output tick_1hz, key_start_n, clr,
        input  sec_ones, sec_tens, min_ones, min_tens, running, rollover
    );

    modport slave (
        input  tick_1hz, key_start_n, clr,
        output sec_ones, sec_tens, min_ones, min_tens, running, rollover
    );
endinterface

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch with a debounced Start/Pause key, a synchronous clear
// and a one-cycle rollover pulse at the 59:59 -> 00:00 wrap.
module stopwatch_counter #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clk_50MHz,
    input  logic                rst,
    stopwatch_counter_if.slave  sw
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    logic [1:0]       rst_pipe;
    logic             rst_sync;
    logic [1:0]       key_pipe;
    logic             key_sync;
    logic             db_level;
    logic [CNT_W-1:0] db_count;
    logic             press;
    state_t           state;
    state_t           next_state;
    logic [3:0]       sec_ones_q;
    logic [3:0]       sec_tens_q;
    logic [3:0]       min_ones_q;
    logic [3:0]       min_tens_q;
    logic             running_q;
    logic             rollover_q;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            rst_pipe <= 2'b11;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b0};
        end
    end

    assign rst_sync = rst_pipe[1];

    always_ff @(posedge clk_50MHz or posedge rst_sync) begin
        if (rst_sync) begin
            key_pipe <= 2'b11;
        end else begin
            key_pipe <= {key_pipe[0], sw.key_start_n};
        end
    end

    assign key_sync = key_pipe[1];

    // A new level is accepted only after it has held for the full window;
    // press fires only when the accepted level falls.
    always_ff @(posedge clk_50MHz or posedge rst_sync) begin
        if (rst_sync) begin
            db_level <= 1'b1;
            db_count <= '0;
            press    <= 1'b0;
        end else begin
            press <= 1'b0;
            if (key_sync != db_level) begin
                if (db_count == CNT_LAST) begin
                    db_level <= key_sync;
                    db_count <= '0;
                    press    <= ~key_sync;
                end else begin
                    db_count <= db_count + 1'b1;
                end
            end else begin
                db_count <= '0;
            end
        end
    end

    always_ff @(posedge clk_50MHz or posedge rst_sync) begin
        if (rst_sync) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (sw.clr) begin
            next_state = IDLE;
        end else if (press) begin
            case (state)
                IDLE:    next_state = RUN;
                RUN:     next_state = PAUSE;
                PAUSE:   next_state = RUN;
                default: next_state = IDLE;
            endcase
        end
    end

    // Ticks are judged against the current state, so a press in the same
    // cycle only affects counting from the following cycle on.
    always_ff @(posedge clk_50MHz or posedge rst_sync) begin
        if (rst_sync) begin
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            rollover_q <= 1'b0;
            running_q  <= (next_state == RUN);
            if (sw.clr) begin
                sec_ones_q <= 4'd0;
                sec_tens_q <= 4'd0;
                min_ones_q <= 4'd0;
                min_tens_q <= 4'd0;
            end else if (sw.tick_1hz && state == RUN) begin
                if (sec_ones_q >= 4'd9) begin
                    sec_ones_q <= 4'd0;
                    if (sec_tens_q >= 4'd5) begin
                        sec_tens_q <= 4'd0;
                        if (min_ones_q >= 4'd9) begin
                            min_ones_q <= 4'd0;
                            if (min_tens_q >= 4'd5) begin
                                min_tens_q <= 4'd0;
                                rollover_q <= 1'b1;
                            end else begin
                                min_tens_q <= min_tens_q + 4'd1;
                            end
                        end else begin
                            min_ones_q <= min_ones_q + 4'd1;
                        end
                    end else begin
                        sec_tens_q <= sec_tens_q + 4'd1;
                    end
                end else begin
                    sec_ones_q <= sec_ones_q + 4'd1;
                end
            end
        end
    end

    assign sw.sec_ones = sec_ones_q;
    assign sw.sec_tens = sec_tens_q;
    assign sw.min_ones = min_ones_q;
    assign sw.min_tens = min_tens_q;
    assign sw.running  = running_q;
    assign sw.rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed, scoreboard-checked bench for stopwatch_counter with a short
// debounce window; expectations come from a seconds-count model.
module tb_stopwatch_counter;

    localparam int DEB = 4;

    typedef struct {
        string       tag;
        logic [15:0] digits;
        logic        run;
        logic        roll;
    } exp_t;

    logic clk_50MHz = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   model_secs;
    bit   model_run;
    bit   model_roll;
    exp_t sb[$];

    stopwatch_counter_if sw();

    stopwatch_counter #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .sw        (sw)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    function automatic logic [15:0] bcd(input int s);
        int m;
        int sec;
        m   = s / 60;
        sec = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
    endfunction

    task automatic pushExpected(input string tag);
        exp_t e;
        e.tag    = tag;
        e.digits = bcd(model_secs);
        e.run    = model_run;
        e.roll   = model_roll;
        sb.push_back(e);
    endtask

    // Pops every pending expectation and compares it with the live outputs.
    task automatic checkOutput();
        exp_t        e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones};
            checks++;
            assert (obs === e.digits) else begin
                failures++;
                $error("[TB] FAIL %s digits: got %h expected %h", e.tag, obs, e.digits);
            end
            checks++;
            assert (sw.running === e.run) else begin
                failures++;
                $error("[TB] FAIL %s running: got %b expected %b", e.tag, sw.running, e.run);
            end
            checks++;
            assert (sw.rollover === e.roll) else begin
                failures++;
                $error("[TB] FAIL %s rollover: got %b expected %b", e.tag, sw.rollover, e.roll);
            end
        end
    endtask

    task automatic applyStimulus(input bit t, input bit c, input string tag);
        @(negedge clk_50MHz);
        checkOutput();
        sw.tick_1hz = t;
        sw.clr      = c;
        model_roll  = 1'b0;
        if (c) begin
            model_secs = 0;
            model_run  = 1'b0;
        end else if (t && model_run) begin
            model_secs++;
            if (model_secs == 3600) begin
                model_secs = 0;
                model_roll = 1'b1;
            end
        end
        pushExpected(tag);
    endtask

    task automatic flush();
        @(negedge clk_50MHz);
        checkOutput();
        sw.tick_1hz = 1'b0;
        sw.clr      = 1'b0;
        model_roll  = 1'b0;
    endtask

    task automatic pressKey(input int bounces, input int hold, input bit expect_press,
                            input string tag);
        flush();
        for (int i = 0; i < bounces; i++) begin
            sw.key_start_n = 1'b0;
            @(negedge clk_50MHz);
            sw.key_start_n = 1'b1;
            @(negedge clk_50MHz);
        end
        sw.key_start_n = 1'b0;
        repeat (hold) @(negedge clk_50MHz);
        sw.key_start_n = 1'b1;
        repeat (12) @(negedge clk_50MHz);
        if (expect_press) model_run = !model_run;
        pushExpected(tag);
        checkOutput();
    endtask

    task automatic resetPulse();
        flush();
        #3 rst = 1'b1;
        #1;
        model_secs = 0;
        model_run  = 1'b0;
        model_roll = 1'b0;
        pushExpected("rst_immediate");
        checkOutput();
        #3 rst = 1'b0;
        repeat (4) @(negedge clk_50MHz);
        pushExpected("post_reset");
        checkOutput();
    endtask

    initial begin
        rst            = 1'b1;
        sw.key_start_n = 1'b1;
        sw.tick_1hz    = 1'b0;
        sw.clr         = 1'b0;
        model_secs     = 0;
        model_run      = 1'b0;
        model_roll     = 1'b0;
        repeat (3) @(negedge clk_50MHz);
        pushExpected("reset_state");
        checkOutput();
        rst = 1'b0;
        repeat (4) @(negedge clk_50MHz);

        pressKey(0, 3, 1'b0, "short_press");
        applyStimulus(1'b1, 1'b0, "idle_tick");

        pressKey(3, 6, 1'b1, "press_start");
        repeat (3) applyStimulus(1'b1, 1'b0, "count_to_03");
        repeat (6) applyStimulus(1'b1, 1'b0, "count_to_09");

        pressKey(0, 6, 1'b1, "pause");
        repeat (5) applyStimulus(1'b1, 1'b0, "paused_tick");
        pressKey(0, 6, 1'b1, "resume");
        applyStimulus(1'b1, 1'b0, "count_to_10");

        repeat (744) applyStimulus(1'b1, 1'b0, "count_to_1234");
        applyStimulus(1'b1, 1'b1, "clr_with_tick");
        repeat (3) applyStimulus(1'b1, 1'b0, "tick_after_clr");

        pressKey(0, 6, 1'b1, "restart");
        repeat (3598) applyStimulus(1'b1, 1'b0, "count_to_5958");
        applyStimulus(1'b1, 1'b0, "count_to_5959");
        applyStimulus(1'b1, 1'b0, "wrap");
        applyStimulus(1'b1, 1'b0, "after_wrap");
        repeat (3598) applyStimulus(1'b1, 1'b0, "count_to_5959_again");
        applyStimulus(1'b1, 1'b1, "clr_on_wrap");
        applyStimulus(1'b0, 1'b0, "after_clr_wrap");

        pressKey(0, 6, 1'b1, "start_for_reset");
        repeat (307) applyStimulus(1'b1, 1'b0, "count_to_0507");
        resetPulse();
        applyStimulus(1'b1, 1'b0, "tick_after_reset");
        pressKey(0, 6, 1'b1, "press_after_reset");
        applyStimulus(1'b1, 1'b0, "count_after_reset");
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1000000, number of consecutive clk_50MHz cycles a synchronized key level must hold before it is accepted (20 ms at 50 MHz).
REQ-002 Port: clk_50MHz  input  1  single system clock; all state is on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous assert, active-high.
REQ-004 Port: tick_1hz  input  1  one-cycle enable pulse at 1 Hz, synchronous to clk_50MHz.
REQ-005 Port: key_start_n  input  1  raw Start/Pause pushbutton, active-low, asynchronous and bouncing.
REQ-006 Port: clr  input  1  synchronous clear request, active-high, level-sampled every cycle.
REQ-007 Port: sec_ones  output  4  BCD ones of seconds, range 0-9.
REQ-008 Port: sec_tens  output  4  BCD tens of seconds, range 0-5.
REQ-009 Port: min_ones  output  4  BCD ones of minutes, range 0-9.
REQ-010 Port: min_tens  output  4  BCD tens of minutes, range 0-5.
REQ-011 Port: running  output  1  high while the FSM is in RUN.
REQ-012 Port: rollover  output  1  one-cycle pulse when the count wraps from 59:59 to 00:00.

Function
REQ-013 key_start_n SHALL pass through a 2-flop synchronizer before any other use; sync flops reset to 1.
REQ-014 Debounce: debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any intervening match restarts the counter from 0.
REQ-015 press SHALL be a one-cycle internal pulse on a debounced 1->0 transition; a 0->1 transition SHALL generate no event.
REQ-016 FSM states SHALL be IDLE, RUN and PAUSE.
REQ-017 Transitions on press: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-018 clr SHALL force IDLE and all digits to 0 on the next edge from any state.
REQ-019 clr SHALL take priority over press and tick_1hz in the same cycle.
REQ-020 Count SHALL advance only when tick_1hz=1 and the registered state is RUN; ticks in IDLE or PAUSE SHALL be ignored.
REQ-021 Press and tick in the same cycle: the tick SHALL be evaluated against the pre-transition state (RUN counts, PAUSE does not); the new state SHALL apply from the next cycle.
REQ-022 Digit outputs SHALL be registered and update on the edge that samples tick_1hz (1-cycle latency).
REQ-023 BCD carry chain: sec_ones 9->0 increments sec_tens; sec_tens 5->0 increments min_ones; min_ones 9->0 increments min_tens; min_tens 5->0 wraps.
REQ-024 59:59 plus a tick SHALL produce 00:00 with rollover=1 for exactly that cycle; state SHALL remain RUN.
REQ-025 rollover SHALL be 0 in all other cycles, including when clr coincides with the wrapping tick.
REQ-026 Digits SHALL never hold non-BCD values or exceed the stated ranges.
REQ-027 running SHALL be a registered decode of the state (1 only in RUN).

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE, all digits=0, running=0, rollover=0, debounced level=1, debounce counter=0, sync flops=1.
REQ-029 rst asserted mid-count or mid-debounce SHALL discard all progress; after release the block SHALL behave as at power-up.
REQ-030 rst deassertion SHALL be synchronized to clk_50MHz before it releases state flops.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Hold key_start_n low for 6 cycles with 3 bounce toggles first -> exactly one press; running=1; 3 ticks -> 00:03.
REQ-032 In RUN at 00:09, press, then 5 ticks -> running=0, display frozen at 00:09; press, 1 tick -> 00:10.
REQ-033 Preload RUN at 59:58, 2 ticks -> 59:59, then 00:00 with rollover high exactly 1 cycle; running stays 1.
REQ-034 In RUN at 12:34, assert clr and tick_1hz in the same cycle -> next cycle 00:00, state IDLE, rollover=0; later ticks ignored.
REQ-035 In RUN at 05:07, pulse rst asynchronously between clock edges -> outputs 0 immediately; after release a single press is required before counting resumes.
REQ-036 Key low for only 3 cycles, then high -> no press, state unchanged.
